// File: rtl/fetch_stage.sv
// fetch_stage: rv32i instruction fetch with a single-outstanding imem port feeding the IF/ID register.
// Optional performance counters (instr_cnt, bubble_cnt) are built only when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        pcsrcE,
  input  logic [31:0] pctargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic [31:0] pcplus4D,
  output logic        validD,
  output logic [31:0] instr_cnt,
  output logic [31:0] bubble_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [1:0]  state;
  logic [1:0]  stateNext;
  logic [31:0] pcF;
  logic [31:0] pcFNext;
  logic [31:0] reqPc;
  logic [31:0] reqPcNext;
  logic        kill;
  logic        killNext;
  logic [31:0] skidInstr;
  logic [31:0] skidPc;
  logic        skidLoad;
  logic        deliver;
  logic [31:0] deliverInstr;
  logic [31:0] deliverPc;

  assign imem_req  = (state == REQ);
  assign imem_addr = pcF;

  // Next-state logic; a redirect always wins over the sequential pcF+4 update.
  always_comb begin
    stateNext    = state;
    pcFNext      = pcF;
    reqPcNext    = reqPc;
    killNext     = kill;
    skidLoad     = 1'b0;
    deliver      = 1'b0;
    deliverInstr = imem_rdata;
    deliverPc    = reqPc;
    case (state)
      IDLE: begin
        stateNext = REQ;
      end
      REQ: begin
        if (imem_gnt) begin
          reqPcNext = pcF;
          pcFNext   = pcF + 32'd4;
          killNext  = pcsrcE;
          stateNext = WAIT;
        end
        if (pcsrcE) begin
          pcFNext = pctargetE;
        end
      end
      WAIT: begin
        if (pcsrcE) begin
          pcFNext = pctargetE;
        end
        if (imem_rvalid) begin
          killNext  = 1'b0;
          stateNext = REQ;
          // A response coinciding with a redirect belongs to the old path.
          if (!kill && !pcsrcE) begin
            if (stallD) begin
              skidLoad  = 1'b1;
              stateNext = HOLD;
            end else begin
              deliver = 1'b1;
            end
          end
        end else if (pcsrcE) begin
          killNext = 1'b1;
        end
      end
      HOLD: begin
        if (pcsrcE) begin
          pcFNext   = pctargetE;
          stateNext = REQ;
        end else if (!stallD) begin
          deliver      = 1'b1;
          deliverInstr = skidInstr;
          deliverPc    = skidPc;
          stateNext    = REQ;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pcF   <= RESET_PC;
      reqPc <= RESET_PC;
      kill  <= 1'b0;
    end else begin
      state <= stateNext;
      pcF   <= pcFNext;
      reqPc <= reqPcNext;
      kill  <= killNext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skidInstr <= NOP;
      skidPc    <= '0;
    end else if (skidLoad) begin
      skidInstr <= imem_rdata;
      skidPc    <= reqPc;
    end
  end

  // IF/ID register: flush beats stall beats delivery; otherwise a bubble is loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instrD   <= NOP;
      pcD      <= '0;
      pcplus4D <= '0;
      validD   <= 1'b0;
    end else if (flushD) begin
      instrD   <= NOP;
      pcD      <= '0;
      pcplus4D <= '0;
      validD   <= 1'b0;
    end else if (!stallD) begin
      if (deliver) begin
        instrD   <= deliverInstr;
        pcD      <= deliverPc;
        pcplus4D <= deliverPc + 32'd4;
        validD   <= 1'b1;
      end else begin
        instrD   <= NOP;
        pcD      <= '0;
        pcplus4D <= '0;
        validD   <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic        loadValid;
  logic        loadBubble;
  logic [31:0] instrCnt;
  logic [31:0] bubbleCnt;

  assign loadValid  = !flushD && !stallD && deliver;
  assign loadBubble = flushD || (!stallD && !deliver);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instrCnt  <= '0;
      bubbleCnt <= '0;
    end else begin
      if (loadValid) begin
        instrCnt <= instrCnt + 32'd1;
      end
      if (loadBubble) begin
        bubbleCnt <= bubbleCnt + 32'd1;
      end
    end
  end

  assign instr_cnt  = instrCnt;
  assign bubble_cnt = bubbleCnt;
`else
  assign instr_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic against a queue-based model.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stallD;
  logic        flushD;
  logic        pcsrcE;
  logic [31:0] pctargetE;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic [31:0] pcplus4D;
  logic        validD;
  logic [31:0] instr_cnt;
  logic [31:0] bubble_cnt;

  logic        imemReqB;
  logic [31:0] imemAddrB;
  logic [31:0] instrDB;
  logic [31:0] pcDB;
  logic [31:0] pcplus4DB;
  logic        validDB;
  logic [31:0] instrCntB;
  logic [31:0] bubbleCntB;

  fetch_stage #(.RESET_PC(32'h0000_0000)) u0 (
    .clk(clk), .rst(rst), .stallD(stallD), .flushD(flushD), .pcsrcE(pcsrcE),
    .pctargetE(pctargetE), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instrD(instrD), .pcD(pcD), .pcplus4D(pcplus4D), .validD(validD),
    .instr_cnt(instr_cnt), .bubble_cnt(bubble_cnt)
  );

  // Second instance runs in lockstep (same inputs) to exercise a wrapping reset PC.
  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u1 (
    .clk(clk), .rst(rst), .stallD(stallD), .flushD(flushD), .pcsrcE(pcsrcE),
    .pctargetE(pctargetE), .imem_req(imemReqB), .imem_addr(imemAddrB),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instrD(instrDB), .pcD(pcDB), .pcplus4D(pcplus4DB), .validD(validDB),
    .instr_cnt(instrCntB), .bubble_cnt(bubbleCntB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: pending fetch as a flag, fetched-but-stalled work as a queue.
  bit          mIdle;
  bit          mInflight;
  bit          mStale;
  logic [31:0] mInPc;
  logic [31:0] mPc;
  logic [63:0] mSkid[$];
  logic [31:0] eInstr, ePc, ePc4, eIc, eBc;
  logic        eValid;

  // Memory responder state.
  bit          memBusy;
  int          memWait;
  logic [31:0] memAddr;
  int          dMin, dMax;
  bit          dataMode;
  bit          forceFlag;
  logic [31:0] forcedWord;
  bit          strayRv;
  logic        preReq;
  logic [31:0] preAddr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] hashw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic bit mReqNow();
    return !mIdle && !mInflight && (mSkid.size() == 0);
  endfunction

  task automatic mReset();
    mIdle = 1; mInflight = 0; mStale = 0; mInPc = '0;
    mPc = 32'h0000_0000;
    mSkid.delete();
    eInstr = 32'h0000_0013; ePc = '0; ePc4 = '0; eValid = 1'b0;
    eIc = '0; eBc = '0;
  endtask

  task automatic mBubble();
    eInstr = 32'h0000_0013; ePc = '0; ePc4 = '0; eValid = 1'b0;
    eBc = eBc + 32'd1;
  endtask

  task automatic mTick();
    bit          del;
    logic [31:0] dI;
    logic [31:0] dP;
    del = 0; dI = '0; dP = '0;
    if (mIdle) begin
      mIdle = 0;
    end else if (mReqNow()) begin
      if (imem_gnt) begin
        mInflight = 1; mInPc = mPc; mStale = pcsrcE;
      end
      if (pcsrcE) mPc = pctargetE;
      else if (imem_gnt) mPc = mPc + 32'd4;
    end else if (mInflight) begin
      if (imem_rvalid) begin
        mInflight = 0;
        if (!mStale && !pcsrcE) begin
          if (stallD) mSkid.push_back({mInPc, imem_rdata});
          else begin del = 1; dI = imem_rdata; dP = mInPc; end
        end
      end else if (pcsrcE) begin
        mStale = 1;
      end
      if (pcsrcE) mPc = pctargetE;
    end else begin
      if (pcsrcE) begin
        mSkid.delete(); mPc = pctargetE;
      end else if (!stallD) begin
        {dP, dI} = mSkid.pop_front(); del = 1;
      end
    end
    if (flushD) mBubble();
    else if (!stallD) begin
      if (del) begin
        eInstr = dI; ePc = dP; ePc4 = dP + 32'd4; eValid = 1'b1;
        eIc = eIc + 32'd1;
      end else begin
        mBubble();
      end
    end
  endtask

  task automatic compareAll();
    chk("validD", {31'b0, validD}, {31'b0, eValid});
    chk("instrD", instrD, eInstr);
    chk("pcD", pcD, ePc);
    chk("pcplus4D", pcplus4D, ePc4);
    chk("imem_req", {31'b0, imem_req}, {31'b0, mReqNow()});
    if (mReqNow() || rst) chk("imem_addr", imem_addr, mPc);
`ifdef FETCH_PERF_CNT_EN
    chk("instr_cnt", instr_cnt, eIc);
    chk("bubble_cnt", bubble_cnt, eBc);
`else
    chk("instr_cnt", instr_cnt, 32'd0);
    chk("bubble_cnt", bubble_cnt, 32'd0);
`endif
  endtask

  // One clock: drive the memory response, advance model and memory at the edge, check #1 later.
  task automatic step();
    bit rv;
    rv = (memBusy && memWait == 0) || strayRv;
    imem_rvalid = rv;
    if (rv && memBusy) begin
      if (forceFlag) begin imem_rdata = forcedWord; forceFlag = 0; end
      else imem_rdata = dataMode ? hashw(memAddr) : memAddr;
    end else begin
      imem_rdata = $urandom;
    end
    preReq = imem_req; preAddr = imem_addr;
    @(posedge clk);
    if (rst) mReset(); else mTick();
    if (rst) begin
      memBusy = 0;
    end else begin
      if (imem_rvalid) memBusy = 0;
      if (preReq && imem_gnt) begin
        memBusy = 1; memAddr = preAddr; memWait = $urandom_range(dMax, dMin);
      end else if (memBusy && memWait > 0) begin
        memWait--;
      end
    end
    #1;
    compareAll();
  endtask

  initial begin
    int          n;
    int          seen;
    logic [31:0] heldI, heldP, addrHold, bc0, expDelta;
    logic        heldV;
    logic [31:0] addrsB[$];
    bit          gotB;
    logic [31:0] firstPcB, firstPc4B;

    rst = 1'b1;
    stallD = 0; flushD = 0; pcsrcE = 0; pctargetE = '0;
    imem_gnt = 1; imem_rvalid = 0; imem_rdata = '0;
    memBusy = 0; memWait = 0; memAddr = '0; dMin = 0; dMax = 0;
    dataMode = 0; forceFlag = 0; forcedWord = '0; strayRv = 0;
    mReset();
    step();
    step();
    chk("rst_instrD", instrD, 32'h0000_0013);
    chk("rst_req", {31'b0, imem_req}, 32'd0);

    // Basic streaming, rdata = addr.
    rst = 1'b0;
    n = 0;
    while (!validD && n < 10) begin step(); n++; end
    chk("t1_first_valid", {31'b0, validD}, 32'd1);
    chk("t1_pcD", pcD, 32'h0);
    chk("t1_instrD", instrD, 32'h0);
    chk("t1_pcplus4D", pcplus4D, 32'h4);
    step();
    chk("t1_gap", {31'b0, validD}, 32'd0);
    step();
    chk("t1_second_valid", {31'b0, validD}, 32'd1);
    chk("t1_second_pcD", pcD, 32'h4);

    // Redirect while waiting for the response of 0x8.
    dMin = 2; dMax = 2;
    n = 0;
    while (!(imem_req && imem_addr == 32'h8) && n < 20) begin step(); n++; end
    chk("t2_req8", imem_addr, 32'h8);
    step();
    pcsrcE = 1; pctargetE = 32'h100;
    step();
    pcsrcE = 0;
    n = 0;
    while (!imem_req && n < 20) begin
      chk("t2_no_valid", {31'b0, validD}, 32'd0);
      step(); n++;
    end
    chk("t2_target_addr", imem_addr, 32'h100);
    n = 0;
    while (!validD && n < 20) begin step(); n++; end
    chk("t2_target_pcD", pcD, 32'h100);

    // Stall across the arrival of 0xDEADBEEF.
    dMin = 1; dMax = 1;
    n = 0;
    while (!imem_req && n < 20) begin step(); n++; end
    step();
    step();
    forceFlag = 1; forcedWord = 32'hDEAD_BEEF;
    heldI = instrD; heldP = pcD; heldV = validD;
    stallD = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_hold_instr", instrD, heldI);
      chk("t3_hold_pc", pcD, heldP);
      chk("t3_hold_valid", {31'b0, validD}, {31'b0, heldV});
      chk("t3_no_req", {31'b0, imem_req}, 32'd0);
    end
    stallD = 0;
    step();
    chk("t3_release_valid", {31'b0, validD}, 32'd1);
    chk("t3_release_instr", instrD, 32'hDEAD_BEEF);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (validD && instrD == 32'hDEAD_BEEF) seen++;
    end
    chk("t3_once", seen, 32'd0);

    // Flush together with stall.
    flushD = 1; stallD = 1;
    step();
    chk("t4_valid", {31'b0, validD}, 32'd0);
    chk("t4_nop", instrD, 32'h0000_0013);
    flushD = 0; stallD = 0;

    // Grant withheld for 4 cycles in REQ.
    imem_gnt = 0;
    n = 0;
    while (!imem_req && n < 20) begin step(); n++; end
    chk("t5_in_req", {31'b0, imem_req}, 32'd1);
    addrHold = imem_addr; bc0 = bubble_cnt;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_req_held", {31'b0, imem_req}, 32'd1);
      chk("t5_addr_stable", imem_addr, addrHold);
    end
`ifdef FETCH_PERF_CNT_EN
    expDelta = 32'd4;
`else
    expDelta = 32'd0;
`endif
    chk("t5_bubble_delta", bubble_cnt - bc0, expDelta);
    imem_gnt = 1;

    // Asynchronous reset while a response is outstanding, then a stray response in IDLE.
    dMin = 3; dMax = 3;
    n = 0;
    while (!mInflight && n < 20) begin step(); n++; end
    chk("t6_in_wait", {31'b0, imem_req}, 32'd0);
    #1 rst = 1'b1;
    #1;
    mReset();
    chk("t6_async_valid", {31'b0, validD}, 32'd0);
    chk("t6_async_req", {31'b0, imem_req}, 32'd0);
    chk("t6_async_addr", imem_addr, 32'h0);
    chk("t6_async_addrB", imemAddrB, 32'hFFFF_FFFC);
    step();
    rst = 1'b0;
    dMin = 0; dMax = 0;
    strayRv = 1;
    step();
    strayRv = 0;
    chk("t6_req_after_rst", {31'b0, imem_req}, 32'd1);
    chk("t6_addr_after_rst", imem_addr, 32'h0);

    // Wrapping reset PC on the second instance.
    gotB = 0; firstPcB = '0; firstPc4B = '0;
    n = 0;
    while ((addrsB.size() < 2 || !gotB) && n < 20) begin
      if (imemReqB && addrsB.size() < 2) addrsB.push_back(imemAddrB);
      step(); n++;
      if (validDB && !gotB) begin gotB = 1; firstPcB = pcDB; firstPc4B = pcplus4DB; end
    end
    chk("t7_count", addrsB.size(), 32'd2);
    if (addrsB.size() == 2) begin
      chk("t7_first_addr", addrsB[0], 32'hFFFF_FFFC);
      chk("t7_second_addr", addrsB[1], 32'h0);
    end
    chk("t7_pcDB", firstPcB, 32'hFFFF_FFFC);
    chk("t7_pcplus4DB", firstPc4B, 32'h0);

    // Randomized traffic.
    dataMode = 1; dMin = 0; dMax = 3;
    for (int i = 0; i < 3000; i++) begin
      stallD    = ($urandom_range(99) < 25);
      flushD    = ($urandom_range(99) < 10);
      pcsrcE    = ($urandom_range(99) < 10);
      pctargetE = $urandom;
      imem_gnt  = ($urandom_range(99) < 70);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
